// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART transmitter. Optional sticky overflow flag
// is built only when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [7:0]         i_in_data,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic               i_flush,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic [LEVEL_W-1:0] o_level,
   output logic               o_overflow,
   input  logic               i_ovf_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [7:0]         r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LEVEL_W-1:0] r_level;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic [PTR_W-1:0]   w_wr_ptr_nxt;
   logic [PTR_W-1:0]   w_rd_ptr_nxt;
   logic [LEVEL_W-1:0] w_level_nxt;

   assign w_full  = (r_level == LEVEL_W'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = i_in_valid & ~w_full;
   assign w_pop   = ~w_empty & i_tx_ready;

   assign o_in_ready = ~w_full;
   assign o_tx_valid = ~w_empty;
   assign o_tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign o_level    = r_level;

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_level_nxt  = r_level;
      if (i_flush) begin
         // Flush wins over any push or pop in the same cycle.
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_level_nxt  = '0;
      end else begin
         if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
         if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
         unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LEVEL_W'(1);
            2'b01:   w_level_nxt = r_level - LEVEL_W'(1);
            default: w_level_nxt = r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
      end
   end

   // Storage is deliberately left unreset; occupancy gates every read.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_in_data;
      end
   end

`ifdef UART_TX_FIFO_OVF_EN
   logic r_overflow;
   logic w_overflow_nxt;

   always_comb begin
      w_overflow_nxt = r_overflow;
      if (i_in_valid && w_full) begin
         w_overflow_nxt = 1'b1;
      end else if (i_ovf_clr) begin
         w_overflow_nxt = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_overflow_nxt;
      end
   end

   assign o_overflow = r_overflow;
`else
   logic w_unused_ovf_clr;
   assign w_unused_ovf_clr = i_ovf_clr;
   assign o_overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH = 16).
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tb_tx_ready;
   logic       tx_ready;
   logic [4:0] level;
   logic       overflow;
   logic       ovf_clr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Simple transmitter stand-in: one pop, then busy for the rest of a 10-cycle frame.
   logic       model_en;
   int         model_busy;
   logic [7:0] cap_data [2];
   int         cap_cyc  [2];
   int         n_cap;

`ifdef UART_TX_FIFO_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   assign tx_ready = model_en ? (model_busy == 0) : tb_tx_ready;

   uart_tx_fifo #(.DEPTH(16)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_data  (in_data),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_flush    (flush),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .i_tx_ready (tx_ready),
      .o_level    (level),
      .o_overflow (overflow),
      .i_ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (model_en) begin
         if (tx_ready && tx_valid) begin
            if (n_cap < 2) begin
               cap_data[n_cap] <= tx_data;
               cap_cyc[n_cap]  <= cyc;
            end
            n_cap      <= n_cap + 1;
            model_busy <= 9;
         end else if (model_busy != 0) begin
            model_busy <= model_busy - 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || in_ready !== 1'b1 ||
          level !== 5'd0 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset: got valid=%b data=%h rdy=%b lvl=%0d ovf=%b exp 0 00 1 0 0",
                  tx_valid, tx_data, in_ready, level, overflow);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      in_data  = 8'h41;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41 || level !== 5'd1) begin
         n_errors++;
         $display("FAIL single_push: got valid=%b data=%h lvl=%0d exp 1 41 1",
                  tx_valid, tx_data, level);
      end
      tb_tx_ready = 1'b1;
      step();
      tb_tx_ready = 1'b0;
      n_checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || level !== 5'd0) begin
         n_errors++;
         $display("FAIL single_pop: got valid=%b data=%h lvl=%0d exp 0 00 0",
                  tx_valid, tx_data, level);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) begin
         in_data  = 8'(i);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      n_checks++;
      if (level !== 5'd16 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fill_full: got lvl=%0d rdy=%b exp 16 0", level, in_ready);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (tx_data !== 8'(i) || tx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_order[%0d]: got data=%h valid=%b exp %h 1",
                     i, tx_data, tx_valid, 8'(i));
         end
         tb_tx_ready = 1'b1;
         step();
         tb_tx_ready = 1'b0;
         step();
      end
      n_checks++;
      if (level !== 5'd0 || tx_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL drain_empty: got lvl=%0d valid=%b exp 0 0", level, tx_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) begin
         in_data  = 8'h10 + 8'(i);
         in_valid = 1'b1;
         step();
      end
      in_data     = 8'hAA;
      tb_tx_ready = 1'b1;
      step();
      in_valid    = 1'b0;
      tb_tx_ready = 1'b0;
      n_checks++;
      if (level !== 5'd15 || tx_data !== 8'h11) begin
         n_errors++;
         $display("FAIL ovf_pop: got lvl=%0d head=%h exp 15 11", level, tx_data);
      end
      step();
      n_checks++;
      if (overflow !== OVF_EXP) begin
         n_errors++;
         $display("FAIL ovf_sticky: got %b exp %b", overflow, OVF_EXP);
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_clear: got %b exp 0", overflow);
      end
      for (int i = 1; i < 16; i++) begin
         n_checks++;
         if (tx_data !== 8'h10 + 8'(i)) begin
            n_errors++;
            $display("FAIL ovf_drain[%0d]: got %h exp %h", i, tx_data, 8'h10 + 8'(i));
         end
         tb_tx_ready = 1'b1;
         step();
         tb_tx_ready = 1'b0;
      end
      n_checks++;
      if (level !== 5'd0) begin
         n_errors++;
         $display("FAIL ovf_final_level: got %0d exp 0", level);
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) begin
         in_data  = 8'h20 + 8'(i);
         in_valid = 1'b1;
         step();
      end
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (tx_data !== 8'h20 + 8'(i)) begin
            n_errors++;
            $display("FAIL simul_head[%0d]: got %h exp %h", i, tx_data, 8'h20 + 8'(i));
         end
         in_data     = 8'h25 + 8'(i);
         in_valid    = 1'b1;
         tb_tx_ready = 1'b1;
         step();
         n_checks++;
         if (level !== 5'd5) begin
            n_errors++;
            $display("FAIL simul_level[%0d]: got %0d exp 5", i, level);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (tx_data !== 8'h34 + 8'(i)) begin
            n_errors++;
            $display("FAIL simul_tail[%0d]: got %h exp %h", i, tx_data, 8'h34 + 8'(i));
         end
         step();
      end
      tb_tx_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 7; i++) begin
         in_data  = 8'h60 + 8'(i);
         in_valid = 1'b1;
         step();
      end
      n_checks++;
      if (level !== 5'd7) begin
         n_errors++;
         $display("FAIL flush_pre_level: got %0d exp 7", level);
      end
      in_data     = 8'h77;
      flush       = 1'b1;
      tb_tx_ready = 1'b1;
      step();
      flush       = 1'b0;
      in_valid    = 1'b0;
      tb_tx_ready = 1'b0;
      n_checks++;
      if (level !== 5'd0 || tx_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_clear: got lvl=%0d valid=%b rdy=%b exp 0 0 1",
                  level, tx_valid, in_ready);
      end
      in_data  = 8'h55;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (tx_data !== 8'h55 || level !== 5'd1) begin
         n_errors++;
         $display("FAIL flush_next_head: got %h lvl=%0d exp 55 1", tx_data, level);
      end
      tb_tx_ready = 1'b1;
      step();
      tb_tx_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int budget;
      model_en = 1'b1;
      in_data  = 8'h48;
      in_valid = 1'b1;
      step();
      in_data  = 8'h49;
      step();
      in_valid = 1'b0;
      budget   = 0;
      while (n_cap < 2 && budget < 100) begin
         step();
         budget++;
      end
      n_checks++;
      if (n_cap < 2) begin
         n_errors++;
         $display("FAIL b2b_timeout: got %0d frames exp 2", n_cap);
      end else begin
         n_checks++;
         if (cap_data[0] !== 8'h48 || cap_data[1] !== 8'h49) begin
            n_errors++;
            $display("FAIL b2b_data: got %h %h exp 48 49", cap_data[0], cap_data[1]);
         end
         n_checks++;
         if (cap_cyc[1] - cap_cyc[0] != 10) begin
            n_errors++;
            $display("FAIL b2b_gap: got %0d cycles exp 10", cap_cyc[1] - cap_cyc[0]);
         end
      end
      n_checks++;
      if (level !== 5'd0 || tx_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_level: got lvl=%0d valid=%b exp 0 0", level, tx_valid);
      end
      model_en = 1'b0;
   endtask

   initial begin
      in_data     = 8'h00;
      in_valid    = 1'b0;
      flush       = 1'b0;
      tb_tx_ready = 1'b0;
      ovf_clr     = 1'b0;
      model_en    = 1'b0;
      model_busy  = 0;
      n_cap       = 0;
      test_reset();
      test_single();
      test_fill_drain();
      test_overflow();
      test_simultaneous();
      test_flush();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
